// File: rtl/rr_reg_arb_pkg.sv
// rr_reg_arb_pkg: shared types and helpers for the round-robin register arbiter
package rr_reg_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, COMMIT} state_t;
  localparam int NREQ_MAX = 8;
  function automatic logic [NREQ_MAX-1:0] onehot(input logic [2:0] idx);
    return NREQ_MAX'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_reg_arbiter_pick.sv
// rr_pick: first set request at or after ptr, wrapping past NREQ-1 back to 0
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            valid,
  output logic [IDW-1:0]  winner
);
  // scan downward so the closest set bit at/after ptr is the last one written
  always_comb begin
    valid  = |req;
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % NREQ]) winner = IDW'((int'(ptr) + i) % NREQ);
  end
endmodule

// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter: round-robin shared register, one write per grant with req/gnt/ack handshake
module rr_reg_arbiter
  import rr_reg_arb_pkg::*;
#(
  parameter int             NREQ      = 4,
  parameter int             DW        = 8,
  parameter logic [DW-1:0]  RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    ack,
  output logic                    busy,
  output logic [DW-1:0]           q
);
  localparam int IDW = $clog2(NREQ);
  state_t          r_state, w_next;
  logic            w_valid;
  logic [IDW-1:0]  w_win, r_gnt_id, r_ptr;
  logic [NREQ-1:0] r_gnt;
  logic [DW-1:0]   r_q;
  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .valid  (w_valid),
    .winner (w_win)
  );
  // state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  // next state: a withdrawn request in GRANT falls straight back to IDLE
  always_comb
    w_next = r_state == IDLE  ? (w_valid ? GRANT : IDLE) :
             r_state == GRANT ? (req[r_gnt_id] ? COMMIT : IDLE) : IDLE;
  // outputs decoded from state and registered datapath
  always_comb begin
    ack    = r_state == COMMIT;
    busy   = r_state != IDLE;
    gnt    = r_gnt;
    gnt_id = r_gnt_id;
    q      = r_q;
  end
  // grant, winner, pointer and shared register; pointer only advances after a real write
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_ptr    <= '0;
      r_q      <= RESET_VAL;
    end else begin
      r_gnt <= (r_state == IDLE && w_valid) ? NREQ'(onehot(3'(w_win))) : '0;
      if (r_state == IDLE && w_valid) r_gnt_id <= w_win;
      if (r_state == GRANT && req[r_gnt_id]) r_q <= wdata[int'(r_gnt_id)*DW +: DW];
      if (r_state == COMMIT) r_ptr <= r_gnt_id == IDW'(NREQ - 1) ? '0 : r_gnt_id + IDW'(1);
    end
endmodule

// File: tb/tb_rr_reg_arbiter.sv
// tb_rr_reg_arbiter: randomized self-checking bench with a transaction-level reference model
module tb_rr_reg_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam logic [DW-1:0] RV = 8'h00;
  logic            clk = 1'b0;
  logic            rstn;
  logic [NREQ-1:0] req;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0] gnt;
  logic [1:0]      gnt_id;
  logic            ack, busy;
  logic [DW-1:0]   q;
  int n_cmp = 0;
  int n_fail = 0;
  int m_ph, m_ptr, m_id;
  logic [DW-1:0] m_q;

  rr_reg_arbiter #(.NREQ(NREQ), .DW(DW), .RESET_VAL(RV)) dut (
    .clk(clk), .rstn(rstn), .req(req), .wdata(wdata),
    .gnt(gnt), .gnt_id(gnt_id), .ack(ack), .busy(busy), .q(q)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_ph = 0; m_ptr = 0; m_id = 0; m_q = RV;
  endtask

  task automatic step();
    bit found = 0;
    case (m_ph)
      0: if (req != 0) begin
           for (int i = 0; i < NREQ; i++)
             if (!found && req[(m_ptr + i) % NREQ]) begin
               m_id = (m_ptr + i) % NREQ; found = 1;
             end
           m_ph = 1;
         end
      1: if (req[m_id]) begin m_q = wdata[m_id*DW +: DW]; m_ph = 2; end
         else m_ph = 0;
      default: begin m_ptr = (m_id + 1) % NREQ; m_ph = 0; end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req = '0;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    n_cmp++; if (q !== RV)      begin n_fail++; $display("FAIL reset_q: got %h want %h", q, RV); end
    n_cmp++; if (gnt !== 4'b0)  begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (ack !== 1'b0)  begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack); end
    n_cmp++; if (gnt_id !== 2'd0) begin n_fail++; $display("FAIL reset_gnt_id: got %0d want 0", gnt_id); end
  endtask

  task automatic test_single();
    apply_reset();
    wdata = '0;
    wdata[2*DW +: DW] = 8'hA5;
    req = 4'b0100;
    step();
    n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b want 0100", gnt); end
    n_cmp++; if (gnt_id !== 2'd2) begin n_fail++; $display("FAIL single_gnt_id: got %0d want 2", gnt_id); end
    n_cmp++; if (ack !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_grant_phase: ack %b busy %b want 0 1", ack, busy); end
    step();
    n_cmp++; if (ack !== 1'b1 || q !== 8'hA5) begin n_fail++; $display("FAIL single_commit: ack %b q %h want 1 a5", ack, q); end
    n_cmp++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL single_gnt_clear: got %b want 0000", gnt); end
    req = '0;
    step();
    n_cmp++; if (busy !== 1'b0 || ack !== 1'b0 || q !== 8'hA5) begin n_fail++; $display("FAIL single_idle: busy %b ack %b q %h want 0 0 a5", busy, ack, q); end
  endtask

  task automatic test_contention();
    logic [DW-1:0] wd [NREQ];
    int k = 0;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      wd[i] = 8'($urandom);
      wdata[i*DW +: DW] = wd[i];
    end
    req = 4'b1111;
    for (int c = 0; c < 40 && k < NREQ; c++) begin
      step();
      if (ack === 1'b1) begin
        n_cmp++; if (gnt_id !== 2'(k)) begin n_fail++; $display("FAIL contention_order: got %0d want %0d", gnt_id, k); end
        n_cmp++; if (q !== wd[k]) begin n_fail++; $display("FAIL contention_q: got %h want %h", q, wd[k]); end
        req[gnt_id] = 1'b0;
        k++;
      end
    end
    n_cmp++; if (k != NREQ) begin n_fail++; $display("FAIL contention_timeout: got %0d writes want %0d", k, NREQ); end
    req = '0;
    step();
  endtask

  task automatic test_wrap();
    int k = 0;
    apply_reset();
    wdata = 32'h44332211;
    req = 4'b0100;
    step(); step();
    req = '0;
    step();
    req = 4'b0011;
    for (int c = 0; c < 20 && k < 2; c++) begin
      step();
      if (ack === 1'b1) begin
        n_cmp++; if (gnt_id !== 2'(k)) begin n_fail++; $display("FAIL wrap_order: got %0d want %0d", gnt_id, k); end
        req[gnt_id] = 1'b0;
        k++;
      end
    end
    n_cmp++; if (k != 2) begin n_fail++; $display("FAIL wrap_timeout: got %0d writes want 2", k); end
    req = '0;
    step();
  endtask

  task automatic test_withdraw();
    apply_reset();
    wdata = 32'h00_77_11_00;
    req = 4'b0010;
    step(); step();
    req = '0;
    step();
    req = 4'b0100;
    step();
    n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL withdraw_gnt: got %b want 0100", gnt); end
    req = '0;
    step();
    n_cmp++; if (ack !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL withdraw_noack: ack %b gnt %b busy %b want 0 0000 0", ack, gnt, busy); end
    n_cmp++; if (q !== 8'h11) begin n_fail++; $display("FAIL withdraw_q: got %h want 11", q); end
    req = 4'b1100;
    step();
    n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL withdraw_ptr: got %b want 0100", gnt); end
    req = '0;
    step(); step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    wdata = 32'h000000_3C;
    wdata[DW +: DW] = 8'hC3;
    req = 4'b0001;
    step(); step();
    req = '0;
    step();
    n_cmp++; if (q !== 8'h3C) begin n_fail++; $display("FAIL rstmid_pre_q: got %h want 3c", q); end
    req = 4'b0010;
    step();
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (q !== RV || gnt !== 4'b0 || ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: q %h gnt %b ack %b busy %b want %h 0000 0 0", q, gnt, ack, busy, RV); end
    #2 rstn = 1'b1;
    model_reset();
    req = '0;
    step();
    n_cmp++; if (ack !== 1'b0 || q !== RV || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: ack %b q %h busy %b want 0 %h 0", ack, q, busy, RV); end
  endtask

  task automatic test_starvation();
    int since = 0;
    int hits = 0;
    apply_reset();
    wdata = 32'($urandom);
    req = 4'b0001;
    for (int c = 0; c < 300; c++) begin
      if (!req[3] && $urandom_range(2) == 0) begin req[3] = 1'b1; since = 0; end
      step();
      if (ack === 1'b1) begin
        if (gnt_id === 2'd3) begin
          n_cmp++; if (since > 1) begin n_fail++; $display("FAIL starve_wait: got %0d other writes want <=1", since); end
          req[3] = 1'b0;
          hits++;
        end else if (req[3]) since++;
      end
    end
    n_cmp++; if (hits == 0) begin n_fail++; $display("FAIL starve_never: got 0 grants to requester 3 want >0"); end
    req = '0;
    step(); step(); step();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] eg;
    apply_reset();
    wdata = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(3) == 0) begin
          req[i] = 1'b1;
          wdata[i*DW +: DW] = 8'($urandom);
        end else if (req[i] && $urandom_range(15) == 0) req[i] = 1'b0;
      step();
      eg = (m_ph == 1) ? 4'(1 << m_id) : 4'b0;
      n_cmp++; if (gnt !== eg) begin n_fail++; $display("FAIL rand_gnt c%0d: got %b want %b", c, gnt, eg); end
      n_cmp++; if (ack !== (m_ph == 2)) begin n_fail++; $display("FAIL rand_ack c%0d: got %b want %b", c, ack, m_ph == 2); end
      n_cmp++; if (busy !== (m_ph != 0)) begin n_fail++; $display("FAIL rand_busy c%0d: got %b want %b", c, busy, m_ph != 0); end
      n_cmp++; if (q !== m_q) begin n_fail++; $display("FAIL rand_q c%0d: got %h want %h", c, q, m_q); end
      if (m_ph != 0) begin
        n_cmp++; if (gnt_id !== 2'(m_id)) begin n_fail++; $display("FAIL rand_gnt_id c%0d: got %0d want %0d", c, gnt_id, m_id); end
      end
      if (m_ph == 2) req[m_id] = 1'b0;
    end
  endtask

  initial begin
    rstn = 1'b0;
    req = '0;
    wdata = '0;
    model_reset();
    #10 rstn = 1'b1;
    #2;
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_withdraw();
    test_reset_mid();
    test_starvation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
